// File: rtl/sram_bank_array.sv
// Banked SRAM array built from 1024x8 single-port macros: valid/ready requests,
// fixed 2-cycle read latency, out-of-range error responses and a full-array clear engine.
module sram_bank_array #(
    parameter int unsigned NBANK      = 64,
    parameter int unsigned DATA_W     = 8,
    parameter logic [7:0]  INIT_VALUE = 8'h00,
    parameter int unsigned BW         = (NBANK > 1) ? $clog2(NBANK) : 1,
    parameter int unsigned AW         = BW + 10
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  INIT_START,
    output logic                  INIT_BUSY,
    output logic                  INIT_DONE,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WE,
    input  logic [DATA_W/8-1:0]   REQ_BE,
    input  logic [AW-1:0]         REQ_ADDR,
    input  logic [DATA_W-1:0]     REQ_WDATA,
    output logic                  RSP_VALID,
    output logic [DATA_W-1:0]     RSP_RDATA,
    output logic                  RSP_ERR
);

    localparam int unsigned NL = DATA_W / 8;
    localparam logic [BW:0] NBANK_L = (BW+1)'(NBANK);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_INIT
    } state_t;

    state_t             state_q, state_d;
    logic               pend_q, pend_d;
    logic [9:0]         cnt_q, cnt_d;
    logic               done_q, done_d;

    logic               s1_valid_q, s1_valid_d;
    logic               s1_err_q, s1_err_d;
    logic [BW-1:0]      s1_bank_q, s1_bank_d;

    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

    logic [BW-1:0]      req_bank;
    logic [9:0]         req_word;
    logic               req_oob;
    logic               req_acc;
    logic               init_wr;
    logic [NBANK-1:0][DATA_W-1:0] bank_o;
    logic [DATA_W-1:0]  rd_or;

    assign req_bank  = REQ_ADDR[AW-1:10];
    assign req_word  = REQ_ADDR[9:0];
    assign req_oob   = {1'b0, req_bank} >= NBANK_L;
    assign REQ_READY = (state_q == ST_IDLE) & ~pend_q & ~INIT_START;
    assign req_acc   = REQ_VALID & REQ_READY;
    assign init_wr   = (state_q == ST_INIT);

    assign INIT_BUSY = pend_q | (state_q != ST_IDLE);
    assign INIT_DONE = done_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_ERR   = rsp_err_q;
    assign RSP_RDATA = rsp_data_q;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    state_d = ST_DRAIN;
                    pend_d  = 1'b0;
                end else if (INIT_START) begin
                    pend_d = 1'b1;
                end
            end
            // Let the last accepted read sample its macros before they are overwritten.
            ST_DRAIN: begin
                if (!s1_valid_q) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                cnt_d = cnt_q + 10'd1;
                if (cnt_q == '1) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_or = '0;
        for (int unsigned b = 0; b < NBANK; b++) begin
            rd_or |= bank_o[b];
        end
        s1_valid_d  = req_acc & ~REQ_WE;
        s1_bank_d   = req_bank;
        s1_err_d    = req_oob;
        rsp_valid_d = s1_valid_q;
        rsp_err_d   = s1_valid_q & s1_err_q;
        rsp_data_d  = (s1_valid_q & ~s1_err_q) ? rd_or : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            pend_q      <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_err_q    <= 1'b0;
            s1_bank_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            s1_valid_q  <= s1_valid_d;
            s1_err_q    <= s1_err_d;
            s1_bank_q   <= s1_bank_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic hit;
        logic rd_sel;

        assign hit    = req_acc & (req_bank == BW'(b));
        assign rd_sel = s1_valid_q & (s1_bank_q == BW'(b));

        // Each lane is one SRAM1RW1024x8: CSB/WEB/OEB active low, registered read port.
        for (genvar l = 0; l < NL; l++) begin : g_lane
            logic       csb;
            logic       web;
            logic       oeb;
            logic [9:0] a;
            logic [7:0] din;
            logic [7:0] dout_q;
            logic [7:0] mem [1024];

            always_comb begin
                if (init_wr) begin
                    csb = 1'b0;
                    web = 1'b0;
                    a   = cnt_q;
                    din = INIT_VALUE;
                end else begin
                    csb = ~(hit & (~REQ_WE | REQ_BE[l]));
                    web = ~REQ_WE;
                    a   = req_word;
                    din = REQ_WDATA[8*l +: 8];
                end
                oeb = ~rd_sel;
            end

            always_ff @(posedge CLK) begin
                if (!csb) begin
                    if (!web) begin
                        mem[a] <= din;
                    end else begin
                        dout_q <= mem[a];
                    end
                end
            end

            assign bank_o[b][8*l +: 8] = oeb ? 8'h00 : dout_q;
        end
    end

endmodule

// File: tb/tb_sram_bank_array.sv
// Randomised and directed bench for sram_bank_array (5 banks, 32-bit words, clear value 0x3C)
// against a transaction-level memory/response model.
module tb_sram_bank_array;

    localparam int NB = 5;
    localparam int DW = 32;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        INIT_START = 1'b0;
    logic        INIT_BUSY;
    logic        INIT_DONE;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic        REQ_WE = 1'b0;
    logic [3:0]  REQ_BE = '0;
    logic [12:0] REQ_ADDR = '0;
    logic [31:0] REQ_WDATA = '0;
    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;

    always #5 CLK = ~CLK;

    sram_bank_array #(
        .NBANK(NB),
        .DATA_W(DW),
        .INIT_VALUE(8'h3C)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .INIT_START(INIT_START),
        .INIT_BUSY(INIT_BUSY),
        .INIT_DONE(INIT_DONE),
        .REQ_VALID(REQ_VALID),
        .REQ_READY(REQ_READY),
        .REQ_WE(REQ_WE),
        .REQ_BE(REQ_BE),
        .REQ_ADDR(REQ_ADDR),
        .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID),
        .RSP_RDATA(RSP_RDATA),
        .RSP_ERR(RSP_ERR)
    );

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic [31:0] mem [NB][1024];
    rsp_t        q[$];
    int          cyc = 0;
    bit          clr_on = 1'b0;
    int          s = 0;
    int          done_at = -1;
    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Clear timeline: START in cycle s, busy from s+1, one pending cycle, one drain cycle,
    // 1024 write cycles (s+3..s+1026), INIT_DONE in s+1027.
    always @(posedge CLK) begin : model
        int   b;
        int   w;
        rsp_t r;
        if (RST) begin
            q.delete();
            clr_on  = 1'b0;
            done_at = -1;
        end else begin
            if (REQ_VALID && !clr_on && !INIT_START) begin
                b = int'(REQ_ADDR[12:10]);
                w = int'(REQ_ADDR[9:0]);
                if (REQ_WE) begin
                    if (b < NB) begin
                        for (int l = 0; l < 4; l++) begin
                            if (REQ_BE[l]) mem[b][w][8*l +: 8] = REQ_WDATA[8*l +: 8];
                        end
                    end
                end else begin
                    r.due  = cyc + 2;
                    r.err  = (b >= NB);
                    r.data = r.err ? 32'h0 : mem[b][w];
                    q.push_back(r);
                end
            end
            if (clr_on && cyc == s + 1026) begin
                for (int bb = 0; bb < NB; bb++)
                    for (int ww = 0; ww < 1024; ww++)
                        mem[bb][ww] = 32'h3C3C3C3C;
                clr_on  = 1'b0;
                done_at = cyc + 1;
            end else if (INIT_START && !clr_on) begin
                clr_on = 1'b1;
                s      = cyc;
            end
        end
        cyc++;
    end

    always @(negedge CLK) begin : compare
        bit ev;
        if (chk_en) begin
            ev = (q.size() > 0) && (q[0].due == cyc);
            chk("ready", 32'(REQ_READY), 32'(!clr_on && !INIT_START));
            chk("busy", 32'(INIT_BUSY), 32'(clr_on));
            chk("done", 32'(INIT_DONE), 32'(cyc == done_at));
            chk("rsp_valid", 32'(RSP_VALID), 32'(ev));
            if (ev) begin
                chk("rsp_err", 32'(RSP_ERR), 32'(q[0].err));
                chk("rsp_rdata", RSP_RDATA, q[0].data);
                void'(q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic req(input logic we, input logic [3:0] be, input logic [12:0] addr,
                       input logic [31:0] wd);
        REQ_VALID = 1'b1;
        REQ_WE    = we;
        REQ_BE    = be;
        REQ_ADDR  = addr;
        REQ_WDATA = wd;
        step();
        REQ_VALID = 1'b0;
    endtask

    task automatic rd_lit(input string nm, input logic [12:0] addr, input logic [31:0] exp_d,
                          input logic exp_e);
        req(1'b0, 4'h0, addr, 32'h0);
        step();
        chk({nm, "_valid"}, 32'(RSP_VALID), 32'd1);
        chk({nm, "_err"}, 32'(RSP_ERR), 32'(exp_e));
        chk({nm, "_data"}, RSP_RDATA, exp_d);
    endtask

    // Entered in the cycle after INIT_START; returns cycles from START to INIT_DONE.
    task automatic wait_done(input bit poke_mid, output int n);
        n = 1;
        while (!INIT_DONE && n < 1200) begin
            step();
            n++;
            INIT_START = poke_mid && (n == 500);
        end
        INIT_START = 1'b0;
    endtask

    task automatic check_clear(input string nm);
        logic [9:0] words [3];
        words[0] = 10'd0;
        words[1] = 10'd511;
        words[2] = 10'd1023;
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < 3; k++)
                rd_lit(nm, {3'(b), words[k]}, 32'h3C3C3C3C, 1'b0);
    endtask

    initial begin : stim
        int lat;
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : main
        int lat;
        logic [2:0] bk;
        step();
        step();
        chk_en = 1'b1;
        chk("rst_busy", 32'(INIT_BUSY), 32'd0);
        chk("rst_done", 32'(INIT_DONE), 32'd0);
        chk("rst_valid", 32'(RSP_VALID), 32'd0);
        chk("rst_rdata", RSP_RDATA, 32'd0);
        chk("rst_err", 32'(RSP_ERR), 32'd0);
        chk("rst_ready", 32'(REQ_READY), 32'd1);
        RST = 1'b0;
        step();

        // Lowest and highest in-range addresses, read back to back.
        req(1'b1, 4'hF, 13'h0000, 32'hA5A5A5A5);
        req(1'b1, 4'hF, 13'h13FF, 32'h5C5C5C5C);
        req(1'b0, 4'h0, 13'h0000, 32'h0);
        req(1'b0, 4'h0, 13'h13FF, 32'h0);
        chk("lo_data", RSP_RDATA, 32'hA5A5A5A5);
        step();
        chk("hi_data", RSP_RDATA, 32'h5C5C5C5C);
        chk("hi_err", 32'(RSP_ERR), 32'd0);

        // Partial byte-enable write.
        req(1'b1, 4'hF, 13'h0805, 32'h11223344);
        req(1'b1, 4'b0101, 13'h0805, 32'hFFFFFFFF);
        rd_lit("be", 13'h0805, 32'h11FF33FF, 1'b0);

        // Out-of-range bank: error response, write dropped.
        rd_lit("oob", 13'h1C00, 32'h0, 1'b1);
        req(1'b1, 4'hF, 13'h1C00, 32'hDEADBEEF);
        req(1'b1, 4'hF, 13'h1400, 32'hDEADBEEF);
        rd_lit("alias", 13'h0000, 32'hA5A5A5A5, 1'b0);

        // Read in the cycle after a write to the same address.
        req(1'b1, 4'hF, 13'h0C07, 32'h0BADF00D);
        rd_lit("wr_rd", 13'h0C07, 32'h0BADF00D, 1'b0);

        // Streaming reads across alternating banks.
        for (int i = 0; i < 16; i++)
            req(1'b1, 4'hF, {3'(i % NB), 10'(i)}, $urandom);
        for (int i = 0; i < 16; i++)
            req(1'b0, 4'h0, {3'(i % NB), 10'(i)}, 32'h0);
        repeat (3) step();

        // Clear requested one cycle after a read is accepted; a mid-clear START is ignored.
        req(1'b0, 4'h0, 13'h0805, 32'h0);
        INIT_START = 1'b1;
        step();
        INIT_START = 1'b0;
        chk("pre_clear_data", RSP_RDATA, 32'h11FF33FF);
        wait_done(1'b1, lat);
        chk("init_latency", 32'(lat), 32'd1027);
        step();
        check_clear("clr1");

        // Random traffic, including out-of-range banks and idle cycles.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                bk = 3'($urandom_range(0, 7));
                req(1'($urandom_range(0, 1)), 4'($urandom), {bk, 10'($urandom_range(0, 1023))},
                    $urandom);
            end else begin
                step();
            end
        end
        repeat (3) step();

        // Reset 300 cycles into a clear.
        INIT_START = 1'b1;
        step();
        INIT_START = 1'b0;
        repeat (299) step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("abort_busy", 32'(INIT_BUSY), 32'd0);
        chk("abort_done", 32'(INIT_DONE), 32'd0);
        chk("abort_valid", 32'(RSP_VALID), 32'd0);
        chk("abort_rdata", RSP_RDATA, 32'd0);
        chk("abort_err", 32'(RSP_ERR), 32'd0);
        chk("abort_ready", 32'(REQ_READY), 32'd1);
        repeat (1100) step();

        INIT_START = 1'b1;
        step();
        INIT_START = 1'b0;
        wait_done(1'b0, lat);
        chk("init_latency2", 32'(lat), 32'd1027);
        step();
        check_clear("clr2");
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
